// File: rtl/hazard_if.sv
// Hazard-control bundle between the pipeline datapath (master) and hazard_unit (slave).
// Carries the decode/execute register indices in, and the forward/stall/flush controls out.
interface hazard_if #(
  parameter int op_width          = 5,
  parameter int forward_sel_width = 2,
  parameter int cnt_width         = 16
);
  logic [op_width-1:0]          rs_d;
  logic [op_width-1:0]          rt_d;
  logic [op_width-1:0]          rs_e;
  logic [op_width-1:0]          rt_e;
  logic [op_width-1:0]          write_reg_e;
  logic                         reg_write_e;
  logic                         mem_to_reg_e;
  logic                         branch_d;
  logic [forward_sel_width-1:0] forward_ae;
  logic [forward_sel_width-1:0] forward_be;
  logic                         forward_ad;
  logic                         forward_bd;
  logic                         stall_f;
  logic                         stall_d;
  logic                         flush_e;
  logic [cnt_width-1:0]         stall_cycles;

  modport master (
    output rs_d, rt_d, rs_e, rt_e, write_reg_e, reg_write_e, mem_to_reg_e, branch_d,
    input  forward_ae, forward_be, forward_ad, forward_bd, stall_f, stall_d, flush_e,
           stall_cycles
  );

  modport slave (
    input  rs_d, rt_d, rs_e, rt_e, write_reg_e, reg_write_e, mem_to_reg_e, branch_d,
    output forward_ae, forward_be, forward_ad, forward_bd, stall_f, stall_d, flush_e,
           stall_cycles
  );
endinterface

// File: rtl/hazard_unit.sv
// MIPS 5-stage hazard controller: E-stage forwarding, load-use stall/flush, stall counter.
// Optional decode-branch forwarding/stall enabled by defining HAZARD_BRANCH_FWD_EN.
module hazard_unit #(
  parameter int op_width          = 5,
  parameter int forward_sel_width = 2,
  parameter int cnt_width         = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  hz
);

  localparam logic [forward_sel_width-1:0] sel_rf  = forward_sel_width'(2'b00);
  localparam logic [forward_sel_width-1:0] sel_wb  = forward_sel_width'(2'b01);
  localparam logic [forward_sel_width-1:0] sel_mem = forward_sel_width'(2'b10);
  localparam logic [op_width-1:0]          reg_zero = {op_width{1'b0}};
  localparam logic [cnt_width-1:0]         cnt_max  = {cnt_width{1'b1}};

  logic [op_width-1:0]          write_reg_m_r;
  logic                         reg_write_m_r;
  logic                         mem_to_reg_m_r;
  logic [op_width-1:0]          write_reg_w_r;
  logic                         reg_write_w_r;
  logic [cnt_width-1:0]         stall_cycles_r;

  logic                         lw_stall_s;
  logic                         branch_stall_s;
  logic                         stall_s;
  logic                         branch_fwd_a_s;
  logic                         branch_fwd_b_s;
  logic [forward_sel_width-1:0] fwd_a_s;
  logic [forward_sel_width-1:0] fwd_b_s;
  logic                         fwd_ad_s;
  logic                         fwd_bd_s;

  // The M shadow holds the newest value, so it is tested before W.
  function automatic logic [forward_sel_width-1:0] fwd_sel(
    input logic [op_width-1:0] src,
    input logic [op_width-1:0] wr_m,
    input logic                rw_m,
    input logic [op_width-1:0] wr_w,
    input logic                rw_w
  );
    logic [forward_sel_width-1:0] sel;
    if ((src != reg_zero) && (src == wr_m) && rw_m) begin
      sel = sel_mem;
    end else if ((src != reg_zero) && (src == wr_w) && rw_w) begin
      sel = sel_wb;
    end else begin
      sel = sel_rf;
    end
    return sel;
  endfunction

  // Shadow of the M/W destination bits, advancing every edge regardless of stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_reg_m_r  <= reg_zero;
      reg_write_m_r  <= 1'b0;
      mem_to_reg_m_r <= 1'b0;
      write_reg_w_r  <= reg_zero;
      reg_write_w_r  <= 1'b0;
    end else begin
      write_reg_m_r  <= hz.write_reg_e;
      reg_write_m_r  <= hz.reg_write_e;
      mem_to_reg_m_r <= hz.mem_to_reg_e;
      write_reg_w_r  <= write_reg_m_r;
      reg_write_w_r  <= reg_write_m_r;
    end
  end

`ifdef HAZARD_BRANCH_FWD_EN
  // Branch compare in decode needs the ALU result from M, and must wait on E writers and M loads.
  always_comb begin
    branch_fwd_a_s = (hz.rs_d != reg_zero) && (hz.rs_d == write_reg_m_r) && reg_write_m_r;
    branch_fwd_b_s = (hz.rt_d != reg_zero) && (hz.rt_d == write_reg_m_r) && reg_write_m_r;
    branch_stall_s = hz.branch_d &&
                     ((hz.reg_write_e && (hz.write_reg_e != reg_zero) &&
                       ((hz.write_reg_e == hz.rs_d) || (hz.write_reg_e == hz.rt_d))) ||
                      (mem_to_reg_m_r && (write_reg_m_r != reg_zero) &&
                       ((write_reg_m_r == hz.rs_d) || (write_reg_m_r == hz.rt_d))));
  end
`else
  logic unused_branch_s;
  assign unused_branch_s = hz.branch_d | mem_to_reg_m_r;
  assign branch_fwd_a_s  = 1'b0;
  assign branch_fwd_b_s  = 1'b0;
  assign branch_stall_s  = 1'b0;
`endif

  // Forward selects and stall/flush; everything is forced low while reset is held.
  always_comb begin
    lw_stall_s = hz.mem_to_reg_e && hz.reg_write_e && (hz.write_reg_e != reg_zero) &&
                 ((hz.write_reg_e == hz.rs_d) || (hz.write_reg_e == hz.rt_d));
    if (rst_n) begin
      stall_s  = lw_stall_s | branch_stall_s;
      fwd_a_s  = fwd_sel(hz.rs_e, write_reg_m_r, reg_write_m_r, write_reg_w_r, reg_write_w_r);
      fwd_b_s  = fwd_sel(hz.rt_e, write_reg_m_r, reg_write_m_r, write_reg_w_r, reg_write_w_r);
      fwd_ad_s = branch_fwd_a_s;
      fwd_bd_s = branch_fwd_b_s;
    end else begin
      stall_s  = 1'b0;
      fwd_a_s  = sel_rf;
      fwd_b_s  = sel_rf;
      fwd_ad_s = 1'b0;
      fwd_bd_s = 1'b0;
    end
  end

  // Saturating count of stalled cycles for performance debug.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_r <= {cnt_width{1'b0}};
    end else if (stall_s && (stall_cycles_r != cnt_max)) begin
      stall_cycles_r <= stall_cycles_r + {{(cnt_width-1){1'b0}}, 1'b1};
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  assign hz.forward_ae   = fwd_a_s;
  assign hz.forward_be   = fwd_b_s;
  assign hz.forward_ad   = fwd_ad_s;
  assign hz.forward_bd   = fwd_bd_s;
  assign hz.stall_f      = stall_s;
  assign hz.stall_d      = stall_s;
  assign hz.flush_e      = stall_s;
  assign hz.stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: a stimulus process pushes model expectations, a monitor pops and compares.
module tb_hazard_unit;
  localparam int OPW = 5;
  localparam int FSW = 2;
  localparam int CW  = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_if #(.op_width(OPW), .forward_sel_width(FSW), .cnt_width(CW)) hz ();

  hazard_unit #(.op_width(OPW), .forward_sel_width(FSW), .cnt_width(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  typedef struct packed {
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e;
    logic       rw_e, mr_e, br_d, rst;
  } stim_t;

  typedef struct {
    int    fae, fbe, fad, fbd, stall, cnt;
    string tag;
  } exp_t;

  typedef struct {
    int wr;
    int rw;
    int mr;
  } prod_t;

  exp_t  sb_q[$];
  prod_t older[$];   // older[0] = producer one cycle back (M), older[1] = two back (W)
  int    model_cnt;
  int    compared;
  int    mismatched;

  function automatic stim_t st(int rs_d, int rt_d, int rs_e, int rt_e, int wr_e,
                               int rw, int mr, int br, int rst);
    stim_t s;
    s.rs_d = 5'(rs_d); s.rt_d = 5'(rt_d); s.rs_e = 5'(rs_e); s.rt_e = 5'(rt_e);
    s.wr_e = 5'(wr_e); s.rw_e = 1'(rw); s.mr_e = 1'(mr); s.br_d = 1'(br); s.rst = 1'(rst);
    return s;
  endfunction

  // Newest in-flight producer of src decides: one cycle back -> 2 (ALU out), two back -> 1 (result).
  function automatic int model_fwd(int src);
    for (int age = 0; age < older.size(); age++) begin
      if (src != 0 && older[age].rw != 0 && older[age].wr == src) return (age == 0) ? 2 : 1;
    end
    return 0;
  endfunction

  task automatic step(input stim_t s, input string tag);
    exp_t e;
    int   lw, bst;
    @(posedge clk);
    #1;
    rst_n = s.rst;
    hz.rs_d = s.rs_d; hz.rt_d = s.rt_d; hz.rs_e = s.rs_e; hz.rt_e = s.rt_e;
    hz.write_reg_e = s.wr_e; hz.reg_write_e = s.rw_e; hz.mem_to_reg_e = s.mr_e;
    hz.branch_d = s.br_d;
    e.tag = tag;
    if (!s.rst) begin
      older.delete();
      older.push_back('{0, 0, 0});
      older.push_back('{0, 0, 0});
      model_cnt = 0;
      e.fae = 0; e.fbe = 0; e.fad = 0; e.fbd = 0; e.stall = 0; e.cnt = 0;
    end else begin
      lw = (s.mr_e && s.rw_e && s.wr_e != 0 && (s.wr_e == s.rs_d || s.wr_e == s.rt_d)) ? 1 : 0;
`ifdef HAZARD_BRANCH_FWD_EN
      e.fad = (s.rs_d != 0 && older[0].rw != 0 && older[0].wr == int'(s.rs_d)) ? 1 : 0;
      e.fbd = (s.rt_d != 0 && older[0].rw != 0 && older[0].wr == int'(s.rt_d)) ? 1 : 0;
      bst = (s.br_d && ((s.rw_e && s.wr_e != 0 && (s.wr_e == s.rs_d || s.wr_e == s.rt_d)) ||
             (older[0].mr != 0 && older[0].wr != 0 &&
              (older[0].wr == int'(s.rs_d) || older[0].wr == int'(s.rt_d))))) ? 1 : 0;
`else
      e.fad = 0; e.fbd = 0; bst = 0;
`endif
      e.fae   = model_fwd(int'(s.rs_e));
      e.fbe   = model_fwd(int'(s.rt_e));
      e.stall = lw | bst;
      e.cnt   = model_cnt;
      if (e.stall != 0 && model_cnt < CNT_MAX) model_cnt++;
      older.push_front('{int'(s.wr_e), int'(s.rw_e), int'(s.mr_e)});
      void'(older.pop_back());
    end
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input string tag, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s/%s: got %0d expected %0d at %0t", tag, name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are combinational, so each cycle presents one result mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("forward_ae", e.tag, int'(hz.forward_ae), e.fae);
      chk("forward_be", e.tag, int'(hz.forward_be), e.fbe);
      chk("forward_ad", e.tag, int'(hz.forward_ad), e.fad);
      chk("forward_bd", e.tag, int'(hz.forward_bd), e.fbd);
      chk("stall_f", e.tag, int'(hz.stall_f), e.stall);
      chk("stall_d", e.tag, int'(hz.stall_d), e.stall);
      chk("flush_e", e.tag, int'(hz.flush_e), e.stall);
      chk("stall_cycles", e.tag, int'(hz.stall_cycles), e.cnt);
    end
  end

  initial begin
    compared = 0; mismatched = 0; model_cnt = 0;
    older.push_back('{0, 0, 0});
    older.push_back('{0, 0, 0});
    rst_n = 1'b0;
    hz.rs_d = 5'd0; hz.rt_d = 5'd0; hz.rs_e = 5'd0; hz.rt_e = 5'd0;
    hz.write_reg_e = 5'd0; hz.reg_write_e = 1'b0; hz.mem_to_reg_e = 1'b0; hz.branch_d = 1'b0;

    // Reset with a live load-use condition on the inputs.
    step(st(5, 0, 5, 5, 5, 1, 1, 1, 0), "reset0");
    step(st(5, 0, 5, 5, 5, 1, 1, 1, 0), "reset1");
    step(st(0, 0, 5, 5, 0, 0, 0, 0, 1), "release");

    // ALU back-to-back: r8 seen from M, then W, then gone.
    step(st(0, 0, 0, 0, 8, 1, 0, 0, 1), "alu_prod");
    step(st(0, 0, 8, 0, 0, 0, 0, 0, 1), "alu_m");
    step(st(0, 0, 0, 8, 0, 0, 0, 0, 1), "alu_w");
    step(st(0, 0, 8, 8, 0, 0, 0, 0, 1), "alu_gone");

    // Double hit on r3 (M wins) and r0 never forwards.
    step(st(0, 0, 0, 0, 3, 1, 0, 0, 1), "dbl_p1");
    step(st(0, 0, 0, 0, 3, 1, 0, 0, 1), "dbl_p2");
    step(st(0, 0, 3, 3, 0, 1, 0, 0, 1), "dbl_hit");
    step(st(0, 0, 0, 0, 0, 1, 0, 0, 1), "r0_prod");
    step(st(0, 0, 0, 0, 0, 0, 0, 0, 1), "r0_use");

    // Load-use on r4 via rt_d, then bubble with dependent in E.
    step(st(0, 4, 0, 0, 4, 1, 1, 0, 1), "lu_stall");
    step(st(0, 0, 0, 4, 0, 0, 0, 0, 1), "lu_bubble");
    step(st(0, 0, 0, 0, 0, 0, 0, 0, 1), "lu_after");

    // Branch on r9 behind an ALU writer: stall then decode-forward (only with the macro).
    step(st(9, 0, 0, 0, 9, 1, 0, 1, 1), "br_stall");
    step(st(9, 0, 0, 0, 0, 0, 0, 1, 1), "br_fwd");

    // Reset asserted mid-stall drops everything at once.
    step(st(4, 0, 0, 0, 4, 1, 1, 0, 0), "rst_mid");
    step(st(0, 0, 4, 4, 0, 0, 0, 0, 1), "rst_rel");

    // Counter saturation: 20 held load-use cycles.
    for (int i = 0; i < 20; i++) step(st(6, 0, 0, 0, 6, 1, 1, 0, 1), "sat_hold");
    step(st(0, 0, 0, 0, 0, 0, 0, 0, 1), "sat_check");

    // Randomized traffic over a small register window to provoke hits.
    for (int i = 0; i < 400; i++) begin
      step(st($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 7), ($urandom % 4) != 0,
              ($urandom % 3) == 0, ($urandom % 4) == 0, ($urandom % 60) != 0), "rand");
    end

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
